// File: rtl/voxel_mem_arbiter.sv
// rtl/voxel_mem_arbiter.sv - voxel SRAM arbiter: round-robin reads, priority loader write, full-grid clear
module voxel_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [5*NUM_REQ-1:0] req_ix,
    input  logic [5*NUM_REQ-1:0] req_iy,
    input  logic [5*NUM_REQ-1:0] req_iz,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_occ,
    input  logic                 wr_valid,
    input  logic [4:0]           wr_ix,
    input  logic [4:0]           wr_iy,
    input  logic [4:0]           wr_iz,
    input  logic                 wr_data,
    output logic                 wr_ready,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [14:0]          mem_addr,
    output logic                 mem_wdata,
    input  logic                 mem_rdata
);

    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                         state_q;
    logic [14:0]                    clr_cnt_q;
    logic [ID_W-1:0]                rr_ptr_q;
    logic [RD_LATENCY-1:0]          pipe_v_q;
    logic [RD_LATENCY-1:0][ID_W-1:0] pipe_id_q;

    logic                           gnt_valid;
    logic [ID_W-1:0]                gnt_id;
    logic [ID_W-1:0]                rr_next;
    logic [ID_W-1:0]                idx;
    logic [14:0]                    req_addr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign req_addr[g] = {req_iz[5*g+4:5*g], req_iy[5*g+4:5*g], req_ix[5*g+4:5*g]};
    end

    // Grants are gated by rst_n so every output is quiet while reset is held.
    always_comb begin
        req_ready = '0;
        wr_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_cnt_q;
            end else if (wr_valid) begin
                wr_ready  = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {wr_iz, wr_iy, wr_ix};
                mem_wdata = wr_data;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                    if (!gnt_valid && req_valid[idx]) begin
                        gnt_valid = 1'b1;
                        gnt_id    = idx;
                    end
                end
                if (gnt_valid) begin
                    req_ready[gnt_id] = 1'b1;
                    mem_en            = 1'b1;
                    mem_addr          = req_addr[gnt_id];
                end
            end
        end
    end

    assign rr_next  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign clr_busy = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            pipe_v_q  <= '0;
            pipe_id_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (clr_start) begin
                    state_q   <= CLEAR;
                    clr_cnt_q <= '0;
                end
            end else begin
                // Leave on the last address so the counter never wraps into a second pass.
                if (clr_cnt_q == 15'h7FFF) begin
                    state_q   <= IDLE;
                    clr_cnt_q <= '0;
                end else begin
                    clr_cnt_q <= clr_cnt_q + 15'd1;
                end
            end
            if (gnt_valid) begin
                rr_ptr_q <= rr_next;
            end
            pipe_v_q[0]  <= gnt_valid;
            pipe_id_q[0] <= gnt_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_id_q[i] <= pipe_id_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_occ   = 1'b0;
        if (pipe_v_q[RD_LATENCY-1]) begin
            rsp_valid[pipe_id_q[RD_LATENCY-1]] = 1'b1;
            rsp_occ                            = mem_rdata;
        end
    end

endmodule

// File: tb/tb_voxel_mem_arbiter.sv
// tb/tb_voxel_mem_arbiter.sv - randomized bench for voxel_mem_arbiter against a grid/queue reference model
module tb_voxel_mem_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [5*N-1:0] req_ix, req_iy, req_iz;
    logic           wr_valid, wr_data, clr_start;
    logic [4:0]     wr_ix, wr_iy, wr_iz;

    logic [N-1:0] a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
    logic         a_rsp_occ, a_wr_ready, a_clr_busy, a_mem_en, a_mem_we, a_mem_wdata, a_mem_rdata;
    logic         b_rsp_occ, b_wr_ready, b_clr_busy, b_mem_en, b_mem_we, b_mem_wdata, b_mem_rdata;
    logic [14:0]  a_mem_addr, b_mem_addr;

    voxel_mem_arbiter #(.NUM_REQ(N), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ix(req_ix), .req_iy(req_iy),
        .req_iz(req_iz), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_occ(a_rsp_occ),
        .wr_valid(wr_valid), .wr_ix(wr_ix), .wr_iy(wr_iy), .wr_iz(wr_iz), .wr_data(wr_data),
        .wr_ready(a_wr_ready), .clr_start(clr_start), .clr_busy(a_clr_busy), .mem_en(a_mem_en),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    voxel_mem_arbiter #(.NUM_REQ(N), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ix(req_ix), .req_iy(req_iy),
        .req_iz(req_iz), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_occ(b_rsp_occ),
        .wr_valid(wr_valid), .wr_ix(wr_ix), .wr_iy(wr_iy), .wr_iz(wr_iz), .wr_data(wr_data),
        .wr_ready(b_wr_ready), .clr_start(clr_start), .clr_busy(b_clr_busy), .mem_en(b_mem_en),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // SRAM macro stand-ins, one per instance, with the matching read latency.
    bit       sram_a [32768];
    bit       sram_b [32768];
    bit       rd_a;
    bit [2:0] rd_b;
    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) sram_a[a_mem_addr] <= a_mem_wdata;
        if (b_mem_en && b_mem_we) sram_b[b_mem_addr] <= b_mem_wdata;
        rd_a <= a_mem_en && !a_mem_we && sram_a[a_mem_addr];
        rd_b <= {rd_b[1:0], b_mem_en && !b_mem_we && sram_b[b_mem_addr]};
    end
    assign a_mem_rdata = rd_a;
    assign b_mem_rdata = rd_b[2];

    typedef struct {
        bit v;
        int id;
        bit occ;
    } rsp_t;

    bit   grid [32768];
    bit   busy;
    int   caddr;
    int   rr;
    rsp_t hist [$];

    int vectors = 0;
    int miscompares = 0;

    bit       m_gv, m_wr;
    int       m_gid;
    logic [N-1:0] e_rdy;
    logic     e_wrdy, e_en, e_we, e_wd;
    logic [14:0] e_addr;

    bit pend [N];
    bit wr_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_rsp(input int lat, output logic [N-1:0] rv, output logic occ);
        rv  = '0;
        occ = 1'b0;
        if (hist.size() >= lat && hist[hist.size()-lat].v) begin
            rv  = N'(1) << hist[hist.size()-lat].id;
            occ = hist[hist.size()-lat].occ;
        end
    endfunction

    task automatic check_dut(input string d, input int lat, input logic [N-1:0] rdy, input logic wrdy,
                             input logic en, input logic we, input logic [14:0] addr, input logic wd,
                             input logic bsy, input logic [N-1:0] rv, input logic occ);
        logic [N-1:0] erv;
        logic         eocc;
        exp_rsp(lat, erv, eocc);
        chk({d, "_req_ready"}, 32'(rdy), 32'(e_rdy));
        chk({d, "_wr_ready"}, 32'(wrdy), 32'(e_wrdy));
        chk({d, "_mem"}, {14'b0, en, we, addr, wd}, {14'b0, e_en, e_we, e_addr, e_wd});
        chk({d, "_clr_busy"}, 32'(bsy), 32'(busy));
        chk({d, "_rsp"}, {27'b0, rv, occ}, {27'b0, erv, eocc});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, {3'b0, a_req_ready, a_wr_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata,
                          a_clr_busy, a_rsp_valid, a_rsp_occ}, 32'd0);
        chk({tag, "_b"}, {3'b0, b_req_ready, b_wr_ready, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata,
                          b_clr_busy, b_rsp_valid, b_rsp_occ}, 32'd0);
    endtask

    task automatic model_reset();
        busy  = 1'b0;
        caddr = 0;
        rr    = 0;
        hist.delete();
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        rsp_t r;
        @(negedge clk);
        e_rdy = '0; e_wrdy = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = 1'b0;
        m_gv = 1'b0; m_gid = 0; m_wr = 1'b0;
        if (busy) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = 15'(caddr);
        end else if (wr_valid) begin
            m_wr = 1'b1; e_wrdy = 1'b1; e_en = 1'b1; e_we = 1'b1;
            e_addr = {wr_iz, wr_iy, wr_ix}; e_wd = wr_data;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (rr + k) % N;
                if (!m_gv && req_valid[i]) begin
                    m_gv = 1'b1;
                    m_gid = i;
                end
            end
            if (m_gv) begin
                e_rdy = N'(1) << m_gid;
                e_en = 1'b1;
                e_addr = {req_iz[5*m_gid +: 5], req_iy[5*m_gid +: 5], req_ix[5*m_gid +: 5]};
            end
        end
        check_dut("a", 1, a_req_ready, a_wr_ready, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata,
                  a_clr_busy, a_rsp_valid, a_rsp_occ);
        check_dut("b", 3, b_req_ready, b_wr_ready, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata,
                  b_clr_busy, b_rsp_valid, b_rsp_occ);
        r.v = m_gv; r.id = m_gid; r.occ = m_gv ? grid[e_addr] : 1'b0;
        hist.push_back(r);
        if (hist.size() > 4) void'(hist.pop_front());
        if (busy) begin
            grid[caddr] = 1'b0;
            if (caddr == 32767) busy = 1'b0;
            else caddr++;
        end else begin
            if (m_wr) grid[e_addr] = wr_data;
            if (m_gv) rr = (m_gid + 1) % N;
            if (clr_start) begin
                busy = 1'b1;
                caddr = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; wr_valid = 1'b0; wr_data = 1'b0; clr_start = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        wr_pend = 1'b0;
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom % 2 == 0)) begin
                pend[i] = 1'b1;
                req_ix[5*i +: 5] = 5'($urandom_range(0, 3));
                req_iy[5*i +: 5] = 5'($urandom_range(0, 3));
                req_iz[5*i +: 5] = 5'($urandom_range(0, 3));
            end
            req_valid[i] = pend[i];
        end
        if (!wr_pend && ($urandom % 5 == 0)) begin
            wr_pend = 1'b1;
            wr_ix = 5'($urandom_range(0, 3));
            wr_iy = 5'($urandom_range(0, 3));
            wr_iz = 5'($urandom_range(0, 3));
            wr_data = 1'($urandom);
        end
        wr_valid = wr_pend;
    endtask

    task automatic post_random();
        if (m_gv) pend[m_gid] = 1'b0;
        if (m_wr) wr_pend = 1'b0;
    endtask

    task automatic random_run(input int n);
        for (int c = 0; c < n; c++) begin
            drive_random();
            cycle();
            post_random();
        end
        idle_inputs();
    endtask

    initial begin
        int obs, guard;
        req_ix = '0; req_iy = '0; req_iz = '0; wr_ix = '0; wr_iy = '0; wr_iz = '0;
        idle_inputs();
        req_valid = '1;
        wr_valid = 1'b1;
        model_reset();
        #5 check_zero("reset_held");
        @(posedge clk);
        #1 check_zero("reset_after_edge");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin from rr_ptr=0 with everybody asking.
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 32'(a_req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_rsp", 32'(a_rsp_valid), 32'(1 << ((k - 1) % 4)));
            cycle();
        end
        idle_inputs();

        req_valid = 4'b0010;
        req_ix[9:5] = 5'd3; req_iy[9:5] = 5'd5; req_iz[9:5] = 5'd7;
        #1;
        chk("single_addr", 32'(a_mem_addr), 32'h1CA3);
        chk("single_ready", 32'(a_req_ready), 32'b0010);
        cycle();
        idle_inputs();
        #1 chk("single_rsp", 32'(a_rsp_valid), 32'b0010);
        cycle();

        wr_valid = 1'b1; wr_ix = 5'd31; wr_iy = 5'd31; wr_iz = 5'd31; wr_data = 1'b1;
        req_valid = 4'b0001;
        req_ix[4:0] = 5'd31; req_iy[4:0] = 5'd31; req_iz[4:0] = 5'd31;
        #1;
        chk("wpri_wr_ready", 32'(a_wr_ready), 32'd1);
        chk("wpri_mem", {16'b0, a_mem_we, a_mem_addr}, {16'b0, 1'b1, 15'h7FFF});
        chk("wpri_req_ready", 32'(a_req_ready), 32'd0);
        cycle();
        wr_valid = 1'b0;
        #1 chk("wpri_then_read", 32'(a_req_ready), 32'b0001);
        cycle();
        idle_inputs();

        req_valid = 4'b0100; cycle();
        req_valid = 4'b0001; cycle();
        req_valid = 4'b0010; cycle();
        req_valid = 4'b0000;
        #1 chk("lat3_rsp0", 32'(b_rsp_valid), 32'b0100);
        cycle();
        #1 chk("lat3_rsp1", 32'(b_rsp_valid), 32'b0001);
        cycle();
        #1 chk("lat3_rsp2", 32'(b_rsp_valid), 32'b0010);
        cycle();

        random_run(1500);

        // Read of a set voxel one cycle before the clear pulse must still come back.
        req_valid = 4'b0001;
        req_ix[4:0] = 5'd31; req_iy[4:0] = 5'd31; req_iz[4:0] = 5'd31;
        cycle();
        req_valid = 4'b0000;
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        obs = 0;
        guard = 0;
        while (busy && guard < 33000) begin
            drive_random();
            #1 if (a_clr_busy) obs++;
            cycle();
            post_random();
            guard++;
        end
        chk("clr_len", 32'(obs), 32'd32768);
        random_run(300);

        // Loader write and clear pulse together, then reset mid-clear.
        wr_valid = 1'b1; wr_ix = 5'd1; wr_iy = 5'd2; wr_iz = 5'd3; wr_data = 1'b1;
        clr_start = 1'b1;
        #1 chk("wr_with_clr", 32'(a_wr_ready), 32'd1);
        cycle();
        idle_inputs();
        guard = 0;
        while (caddr != 1000 && guard < 2000) begin
            cycle();
            guard++;
        end
        req_valid = '1;
        #1 chk("clr_addr_1000", 32'(a_mem_addr), 32'd1000);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid_clear");
        model_reset();
        rst_n = 1'b1;
        #1;
        chk("post_reset_grant_a", 32'(a_req_ready), 32'b0001);
        chk("post_reset_grant_b", 32'(b_req_ready), 32'b0001);
        cycle();
        idle_inputs();
        random_run(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/voxel_mem_arbiter.md
# voxel_mem_arbiter

Shares the single-port 32x32x32 voxel occupancy SRAM between NUM_REQ traversal read requesters and one scene-loader write port. It also provides a hardware clear sequencer that zeroes the whole grid. Memory addresses are formed as {iz, iy, ix} (z MSB, x LSB, 15 bits). The block sits between the ray traversal lanes / scene loader and the voxel SRAM macro.

## Interface
Parameters:
- NUM_REQ, 4, number of read requesters (2..8)
- RD_LATENCY, 1, SRAM read latency in cycles from mem_en to valid mem_rdata (1..3)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  read request per requester
- req_ix, req_iy, req_iz  in  5*NUM_REQ each  packed coordinates; requester i uses bits [5i+4:5i]
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- rsp_valid  out  NUM_REQ  one-hot; read data for that requester valid this cycle
- rsp_occ  out  1  occupancy bit returned (shared by all requesters)
- wr_valid  in  1  loader write request
- wr_ix, wr_iy, wr_iz  in  5 each  write coordinates
- wr_data  in  1  occupancy bit to write
- wr_ready  out  1  write accepted this cycle
- clr_start  in  1  one-cycle pulse; starts full-grid clear
- clr_busy  out  1  clear in progress
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable (valid with mem_en)
- mem_addr  out  15  SRAM address
- mem_wdata  out  1  SRAM write data
- mem_rdata  in  1  SRAM read data, RD_LATENCY cycles after a read mem_en

## Operation
- FSM states: IDLE, CLEAR. Reset state is IDLE.
- IDLE -> CLEAR on clr_start. The clear counter loads 0 and clr_busy goes 1 on the next cycle.
- CLEAR issues one write per cycle: mem_en=1, mem_we=1, mem_wdata=0, mem_addr=counter. The counter increments by 1 each cycle.
- CLEAR -> IDLE in the cycle the write to address 32767 is issued. The counter must not wrap around and restart the clear.
- clr_start is ignored while in CLEAR.
- In CLEAR, req_ready=0 and wr_ready=0.
- In IDLE, arbitration is evaluated each cycle, combinationally from the inputs:
  - wr_valid has strict priority. wr_ready=1, mem_we=1, mem_addr={wr_iz,wr_iy,wr_ix}, mem_wdata=wr_data. No read is granted that cycle.
  - Otherwise the block grants one read by round-robin among asserted req_valid. The search starts at rr_ptr. The granted requester gets req_ready=1; mem_en=1, mem_we=0, mem_addr is that requester's {iz,iy,ix}.
  - rr_ptr updates to (granted+1) mod NUM_REQ after each read grant. rr_ptr is unchanged on write or idle cycles.
- Valid/ready handshake: requesters hold valid and coordinates stable until ready. Inputs are never dropped or reordered per requester.
- Read return pipeline:
  - A RD_LATENCY-deep shift register carries (valid, requester id).
  - rsp_valid[id]=1 and rsp_occ=mem_rdata exactly RD_LATENCY cycles after the grant cycle.
  - Responses have no backpressure.
- The pipeline keeps draining through a clr_start. Reads granted before CLEAR still return.
- When mem_en=0, mem_we, mem_addr and mem_wdata are 0.
- rsp_occ is 0 when no rsp_valid bit is set.

## Timing
- Reset values:
  - All outputs 0; clr_busy=0.
  - rr_ptr=0, state IDLE, clear counter 0, return pipeline empty.
- Grant latency: 0 cycles. req_ready, wr_ready and mem_* are combinational from valid inputs and registered state.
- Read latency: request grant at cycle T gives rsp_valid at T+RD_LATENCY.
- Throughput: one SRAM access per cycle, back-to-back.
- Clear duration: clr_start at cycle T; CLEAR writes occupy cycles T+1..T+32768; clr_busy=1 over exactly those cycles. Arbitration resumes at T+32769.
- clr_start and wr_valid in the same IDLE cycle: the write is granted that cycle, then CLEAR starts.
- Asynchronous reset mid-clear or mid-read:
  - All state returns to reset values immediately.
  - In-flight responses are discarded (rsp_valid=0).
  - The clear is abandoned.

## Test plan
- Single read: NUM_REQ=4, RD_LATENCY=1, req_valid=4'b0010, coords (3,5,7):
  - mem_addr=0x1CA3, req_ready=4'b0010 same cycle.
  - Next cycle rsp_valid=4'b0010, rsp_occ=mem_rdata.
- Round-robin fairness: req_valid=4'b1111 held for 8 cycles with ready requesters re-asserting. Grant order 0,1,2,3,0,1,2,3; rsp_valid order matches, one cycle behind.
- Write priority: wr_valid=1 (31,31,31,data=1) together with req_valid=4'b0001. wr_ready=1, mem_we=1, mem_addr=0x7FFF, req_ready=0; requester 0 is granted the following cycle.
- Clear:
  - Pulse clr_start. clr_busy is high for exactly 32768 cycles; mem_addr steps 0..32767 with mem_we=1, mem_wdata=0.
  - req_ready=0 throughout.
  - A pending read issued one cycle before the pulse still returns.
- Latency parameter: RD_LATENCY=3, grants to requesters 2,0,1 on consecutive cycles. rsp_valid one-hot 4'b0100, 4'b0001, 4'b0010 on cycles T+3, T+4, T+5.
- Reset mid-clear: assert rst_n=0 at clear address 1000. All outputs go 0 asynchronously. After release, state is IDLE, rr_ptr=0, and a new request is granted normally.
